// File: rtl/md5_padder_if.sv
// Byte-stream input and 512-bit block output of the MD5 padder.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready. The producer holds data and flags stable while valid
// is high and ready is low. Valid never waits for ready. Ready may depend on
// state but never on valid in the same cycle.
interface md5_padder_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;

  // Padder side: consumes bytes, produces blocks.
  modport slave (
    input  in_data, in_valid, in_last, in_empty, out_ready,
    output in_ready, out_block, out_valid, out_first, out_last
  );

  // Environment side: produces bytes, consumes blocks.
  modport master (
    output in_data, in_valid, in_last, in_empty, out_ready,
    input  in_ready, out_block, out_valid, out_first, out_last
  );
endinterface

// File: rtl/md5_padder.sv
// MD5 message padder: it packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and the 64-bit little-endian bit length. Block
// byte k sits at out_block[511-8k -: 8], which is the layout the round
// pipeline reads on its m input. The flags out_first and out_last tell the
// chaining logic when to load the IV and when to finalise a digest.
module md5_padder (
  input  logic       clk,
  input  logic       rst,
  md5_padder_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,  // accepting message bytes
    PAD   = 2'd1,  // one cycle: place 0x80 and, if it fits, the length
    EMIT  = 2'd2,  // presenting a finished block
    EXTRA = 2'd3   // one cycle: build the length-only trailing block
  } state_t;

  state_t       state;
  logic [511:0] blk;         // block buffer, driven straight to out_block
  logic [6:0]   bpos;        // next byte position in the block, 0..64
  logic [60:0]  nbytes;      // message length in bytes, wraps mod 2^61
  logic         first_pend;  // next emitted block starts a message
  logic         pend_len;    // length did not fit, so it goes in an extra block
  logic         need80;      // message filled the block exactly, so 0x80 goes in the extra block
  logic         in_ready_q;
  logic         out_valid_q;
  logic         out_first_q;
  logic         out_last_q;

  logic [6:0]   bpos_inc;
  logic [63:0]  len_bits;
  logic [63:0]  len_field;   // length laid out as block bytes 56..63
  logic         in_fire;

  // Byte 56 must hold len[7:0] and byte 63 must hold len[63:56]. Byte 56 sits
  // at blk[63:56], so the length is byte-reversed into the low 64 bits.
  function automatic logic [63:0] byte_rev64(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*(7-i) +: 8] = v[8*i +: 8];
    end
    return r;
  endfunction

  // Derived values used by the state machine.
  always_comb begin
    bpos_inc  = bpos + 7'd1;
    len_bits  = {nbytes, 3'b000};
    len_field = byte_rev64(len_bits);
    in_fire   = bus.in_valid && in_ready_q;
  end

  // Control, counters and block buffer in one registered state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      blk         <= '0;
      bpos        <= '0;
      nbytes      <= '0;
      first_pend  <= 1'b1;
      pend_len    <= 1'b0;
      need80      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            if (bus.in_last && bus.in_empty) begin
              // End marker with no byte: pad whatever is already buffered.
              state      <= PAD;
              in_ready_q <= 1'b0;
            end else begin
              // {~bpos[5:0], 3'b000} equals 504 - 8*bpos, the LSB of byte bpos.
              blk[{~bpos[5:0], 3'b000} +: 8] <= bus.in_data;
              bpos   <= bpos_inc;
              nbytes <= nbytes + 61'd1;
              if (bpos_inc[6]) begin
                // Block is full. It leaves as a data block. If this byte also
                // ended the message, the 0x80 moves into the extra block.
                state       <= EMIT;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_first_q <= first_pend;
                out_last_q  <= 1'b0;
                need80      <= bus.in_last;
              end else if (bus.in_last) begin
                state      <= PAD;
                in_ready_q <= 1'b0;
              end
            end
          end
        end

        PAD: begin
          // bpos is at most 63 here because a full block goes straight to EMIT.
          blk[{~bpos[5:0], 3'b000} +: 8] <= 8'h80;
          if (bpos <= 7'd55) begin
            blk[63:0]  <= len_field;
            out_last_q <= 1'b1;
          end else begin
            pend_len   <= 1'b1;
            out_last_q <= 1'b0;
          end
          state       <= EMIT;
          out_valid_q <= 1'b1;
          out_first_q <= first_pend;
        end

        EMIT: begin
          // Everything stays frozen until the consumer accepts the block.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            blk         <= '0;
            bpos        <= '0;
            first_pend  <= out_last_q;
            if (pend_len || need80) begin
              state <= EXTRA;
            end else begin
              state      <= FILL;
              in_ready_q <= 1'b1;
              if (out_last_q) begin
                nbytes <= '0;
              end
            end
          end
        end

        EXTRA: begin
          // The buffer was cleared on the previous handshake.
          if (need80) begin
            blk[511:504] <= 8'h80;
          end
          blk[63:0]   <= len_field;
          pend_len    <= 1'b0;
          need80      <= 1'b0;
          state       <= EMIT;
          out_valid_q <= 1'b1;
          out_first_q <= first_pend;
          out_last_q  <= 1'b1;
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  // The outputs come straight from the registers.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_block = blk;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder. The expected blocks are built by hand from
// the MD5 padding rules.
module tb_md5_padder;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  md5_padder_if bus();

  md5_padder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [513:0] exp_q[$];   // {block, first, last}

  function automatic logic [513:0] z1(input logic b);
    return {513'd0, b};
  endfunction

  function automatic logic [513:0] mk(input logic [511:0] b, input logic f,
                                      input logic l);
    return {b, f, l};
  endfunction

  task automatic check(input string tag, input logic [513:0] obs,
                       input logic [513:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    int g;
    g = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_empty = e;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) check("in_ready_timeout", z1(bus.in_ready), z1(1'b1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic send_abc();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
  endtask

  // Wait for a block, compare it with the next queued expectation, and accept
  // it. After the handshake, in_ready must be back to 1 only for a final block.
  task automatic collect(input string tag);
    int g;
    logic [513:0] e;
    g = 0;
    while (bus.out_valid !== 1'b1 && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_valid"}, z1(bus.out_valid), z1(1'b1));
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check(tag, {bus.out_block, bus.out_first, bus.out_last}, e);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_in_ready"}, z1(bus.in_ready), z1(e[0]));
  endtask

  logic [511:0] b;
  logic [513:0] abc_exp;
  logic [513:0] empty_exp;

  initial begin
    rst           = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_empty  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    check("rst_out_valid", z1(bus.out_valid), z1(1'b0));
    check("rst_in_ready",  z1(bus.in_ready),  z1(1'b1));
    check("rst_out_first", z1(bus.out_first), z1(1'b0));
    check("rst_out_last",  z1(bus.out_last),  z1(1'b0));
    check("rst_out_block", {bus.out_block, 2'b00}, 514'd0);
    check("rst_state",     {512'd0, dbg_state}, {512'd0, 2'd0});

    // Empty message.
    b = '0; b[511:504] = 8'h80;
    empty_exp = mk(b, 1'b1, 1'b1);
    exp_q.push_back(empty_exp);
    send_beat(8'h00, 1'b1, 1'b1);
    collect("empty");

    // "abc", including the PAD-cycle latency.
    b = '0; b[511:480] = 32'h61626380; b[63:32] = 32'h18000000;
    abc_exp = mk(b, 1'b1, 1'b1);
    exp_q.push_back(abc_exp);
    send_abc();
    check("abc_pad_no_valid", z1(bus.out_valid), z1(1'b0));
    check("abc_pad_no_ready", z1(bus.in_ready),  z1(1'b0));
    @(posedge clk); #1;
    check("abc_emit_valid", z1(bus.out_valid), z1(1'b1));
    collect("abc");

    // 56 zero bytes: the length spills into a second block.
    b = '0; b[63:56] = 8'h80;
    exp_q.push_back(mk(b, 1'b1, 1'b0));
    b = '0; b[63:32] = 32'hC0010000;
    exp_q.push_back(mk(b, 1'b0, 1'b1));
    for (int i = 0; i < 56; i++) send_beat(8'h00, (i == 55), 1'b0);
    collect("z56_b1");
    check("z56_extra_gap", z1(bus.out_valid), z1(1'b0));
    @(posedge clk); #1;
    check("z56_extra_valid", z1(bus.out_valid), z1(1'b1));
    collect("z56_b2");

    // 64 bytes of 0xFF: the 0x80 and the length both go in the extra block.
    b = '1;
    exp_q.push_back(mk(b, 1'b1, 1'b0));
    b = '0; b[511:504] = 8'h80; b[63:32] = 32'h00020000;
    exp_q.push_back(mk(b, 1'b0, 1'b1));
    for (int i = 0; i < 64; i++) send_beat(8'hFF, (i == 63), 1'b0);
    check("ff64_full_valid", z1(bus.out_valid), z1(1'b1));
    collect("ff64_b1");
    collect("ff64_b2");

    // Backpressure: the block is held for 5 cycles, then a new message starts first.
    send_abc();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {bus.out_block, bus.out_first, bus.out_last}, abc_exp);
      check("bp_in_ready", z1(bus.in_ready), z1(1'b0));
      @(posedge clk); #1;
    end
    exp_q.push_back(abc_exp);
    collect("bp_abc");
    exp_q.push_back(empty_exp);
    send_beat(8'h00, 1'b1, 1'b1);
    collect("bp_second_first");

    // Reset in the middle of a message discards it.
    for (int i = 0; i < 10; i++) send_beat(8'h5A, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", z1(bus.out_valid), z1(1'b0));
    check("mid_rst_in_ready",  z1(bus.in_ready),  z1(1'b1));
    check("mid_rst_state",     {512'd0, dbg_state}, {512'd0, 2'd0});
    exp_q.push_back(abc_exp);
    send_abc();
    collect("post_rst_abc");

    check("queue_drained", {482'd0, 32'(exp_q.size())}, 514'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_padder.md
# md5_padder

Front-end stage of the MD5 datapath. It accepts a message as a byte stream, applies MD5 padding (a 0x80 byte, zero fill, then a 64-bit little-endian bit length), and emits complete 512-bit blocks. Each block is in the word/byte layout the round-operation pipeline consumes on its `m` input. It sits directly upstream of the 64-step hash pipeline, and its `out_first`/`out_last` flags tell the chaining logic when to load the IV and when to finalize a digest.

## Interface
- No parameters: block width is 512, byte width is 8, length field is 64 bits; all are fixed by MD5.
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data`/`in_last`/`in_empty` are valid.
- `in_last`  in  1  this beat ends the message.
- `in_empty`  in  1  only meaningful with `in_last`: the beat carries no byte (zero-length message, or an end marker after the final byte).
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `out_block`  out  512  padded block; block byte k is at `out_block[511-8k -: 8]`.
- `out_valid`  out  1  `out_block` and flags are valid.
- `out_ready`  in  1  block consumed when `out_valid && out_ready`.
- `out_first`  out  1  block is the first of its message.
- `out_last`  out  1  block is the final block of its message (carries the length).

## Operation
- States:
  - FILL: `in_ready`=1.
  - PAD: one cycle, applies padding.
  - EMIT: `out_valid`=1.
  - EXTRA: one cycle, builds the extra length-only block.
- Counters and registers:
  - `bpos[6:0]` is the byte position in the current block (0..64).
  - `nbytes[60:0]` is the message byte count; it wraps modulo 2^61, so the length is `{nbytes,3'b0}` modulo 2^64.
  - `first_pend` is set by reset and after each `out_last` handshake, and cleared on each block handshake. It drives `out_first`.
- FILL, accepted beat without `in_empty`:
  - The byte is written at `bpos`, then `bpos`+1 and `nbytes`+1.
  - If `in_last`: go to PAD, unless the new `bpos`=64, in which case go to EMIT with `out_last`=0 and set `need80` (0x80 goes in the extra block).
  - If not `in_last` and the new `bpos`=64: go to EMIT with `out_last`=0.
- FILL, accepted beat with `in_last && in_empty`: go to PAD and write no byte.
- PAD, with n = `bpos`:
  - Write 0x80 at byte n.
  - If n≤55: write length bytes 56..63 (byte 56 = len[7:0] … byte 63 = len[63:56]) and set `out_last`=1.
  - Else: `out_last`=0 and set `pend_len`.
  - Go to EMIT.
- EMIT, on handshake:
  - Clear the buffer to zero and set `bpos`=0.
  - If `pend_len` or `need80`: go to EXTRA.
  - Else: go to FILL. If `out_last`, also clear `nbytes`.
- EXTRA:
  - The buffer is already zero. Write 0x80 at byte 0 if `need80`, write the length at bytes 56..63, set `out_last`=1, clear `pend_len`/`need80`, and go to EMIT.
- Bytes not written in a block are zero.
- `in_valid` low: no state change. `in_ready` low outside FILL. Input signals other than `in_valid` are ignored when no handshake occurs.

## Timing
- Reset values:
  - `out_valid`, `out_first`, `out_last`, `out_block`: all 0.
  - `in_ready`: 1, because state resets to FILL and `in_ready` = (state==FILL).
  - `nbytes`, `bpos`, `pend_len`, `need80`: all 0. `first_pend` = 1.
- A full 64-byte data block: byte 63 accepted at edge t, `out_valid`=1 after edge t.
- Final beat accepted at edge t: PAD during t..t+1, `out_valid`=1 after edge t+1.
- EXTRA block: `out_valid`=1 two edges after the handshake of the preceding block.
- `out_block` and all flags are held stable while `out_valid && !out_ready`.
- `in_ready` returns to 1 the edge after the final handshake of a block.
- Throughput: one byte per cycle in FILL.
- `rst` mid-message or mid-EMIT: the partial message is discarded and the reset values apply after that edge. Nothing is emitted for the aborted message.

## Test plan
- Empty message (`in_last`=`in_empty`=1): one block, `out_block[511:504]`=0x80, all other bits 0, `out_first`=`out_last`=1.
- "abc" (0x61,0x62,0x63, last on 0x63): `out_block[511:480]`=0x61626380, `[63:32]`=0x18000000, rest 0, `out_first`=`out_last`=1. `out_valid` rises 2 edges after 0x63 is accepted.
- 56 bytes of 0x00: two blocks.
  - Block 1: byte 56 = 0x80, `out_first`=1, `out_last`=0.
  - Block 2: all zero except `[63:32]`=0xC0010000, `out_first`=0, `out_last`=1.
- 64 bytes of 0xFF: two blocks.
  - Block 1: all ones, `out_last`=0.
  - Block 2: `[511:504]`=0x80, `[63:32]`=0x00020000, `out_last`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after "abc" is padded. `out_block` and flags stay stable and `in_ready`=0. One edge after the handshake, `in_ready`=1 and a second message gets `out_first`=1.
- Reset after 10 bytes: after the `rst` edge, `out_valid`=0 and `in_ready`=1. A subsequent "abc" reproduces the "abc" result exactly.
